fp_add_arbiter: RTL and testbench

- Shares one multi-cycle single-precision float add/subtract core among NUM_REQ requesters, e.g. the subset-coordinate generators and gradient/interpolation units.
- Round-robin grant, one operation in flight at a time.
- Subtraction is done by flipping the sign of operand b before issue.
- A watchdog returns an error response if the core never reports done.

---
 rtl/fp_add_arbiter_if.sv | 24 ++
 rtl/fp_add_arbiter.sv | 155 +++++++++++++++
 tb/tb_fp_add_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_if.sv
// Requester-side bus of the shared float add/subtract arbiter: packed per-requester
// operation requests in, one-hot result strobes and a shared result bus out.
interface fp_add_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_sub;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_sub, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one multi-cycle float add/sub core among NUM_REQ requesters,
// one operation in flight, with a watchdog that answers qNaN if the core never finishes.
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    fp_add_arbiter_if.slave req_bus,
    output logic            core_start,
    output logic [31:0]     core_a,
    output logic [31:0]     core_b,
    input  logic            core_done,
    input  logic [31:0]     core_result,
    output logic [31:0]     op_count,
    output logic            busy
);

    localparam int          IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          TW   = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    logic [IDW-1:0]       last_grant;
    logic [IDW-1:0]       id_q;
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic [31:0]          result_q;
    logic                 err_q;
    logic [TW-1:0]        timer;
    logic [NUM_REQ-1:0]   rsp_valid_q;

    logic [IDW-1:0]       win_id;
    logic                 win_found;
    logic [31:0]          sel_a;
    logic [31:0]          sel_b;
    logic                 sel_sub;
    int                   cand;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Winner: first valid requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req_bus.req_valid[IDW'(cand)]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == win_id) begin
                sel_a   = req_bus.req_a[32*i +: 32];
                sel_b   = req_bus.req_b[32*i +: 32];
                sel_sub = req_bus.req_sub[i];
            end
        end
    end

    always_comb begin
        req_bus.req_ready = '0;
        if (state == IDLE && win_found) req_bus.req_ready = onehot(win_id);
    end

    assign req_bus.rsp_valid = rsp_valid_q;
    assign req_bus.rsp_data  = result_q;
    assign req_bus.rsp_err   = err_q;
    assign core_a            = a_q;
    assign core_b            = b_q;
    assign busy              = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            timer       <= '0;
            rsp_valid_q <= '0;
            core_start  <= 1'b0;
            op_count    <= '0;
        end else begin
            core_start  <= 1'b0;
            rsp_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        id_q       <= win_id;
                        a_q        <= sel_a;
                        // Subtraction is an add with b's sign flipped.
                        b_q        <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (core_done) begin
                        result_q    <= core_result;
                        err_q       <= 1'b0;
                        rsp_valid_q <= onehot(id_q);
                        state       <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        result_q    <= QNAN;
                        err_q       <= 1'b1;
                        rsp_valid_q <= onehot(id_q);
                        state       <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    last_grant <= id_q;
                    if (!err_q) op_count <= sat_inc(op_count);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized bench for fp_add_arbiter against a cycle-level transaction model
// of the arbitration, latency, timeout and bookkeeping rules.
module tb_fp_add_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        core_start;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_result;
    logic [31:0] op_count;
    logic        busy;

    fp_add_arbiter_if #(.NUM_REQ(N)) bus ();

    fp_add_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_bus     (bus),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .core_result (core_result),
        .op_count    (op_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Requesters
    bit          rv [N];
    bit          rs [N];
    bit          auto_m [N];
    logic [31:0] ra [N];
    logic [31:0] rb [N];
    bit          rand_mode = 1'b0;

    // Transaction model
    bit          out_q = 1'b0;
    int          m_id, m_acc, m_rsp, m_lat;
    logic [31:0] m_a, m_b, m_data;
    bit          m_err;
    int          m_last = N - 1;
    logic [31:0] m_cnt  = '0;
    int          n_done = 0;

    // Core model
    bit          c_pend = 1'b0;
    int          c_cnt;
    logic [31:0] c_res;
    bit          stray = 1'b0;
    int          cur_lat = 0;
    int          force_lat = -1;

    // Observations
    int          grant_log[$];
    logic [31:0] last_data, last_core_b;
    bit          last_err;
    int          last_rsp_cyc;
    bit          seen_ready3, seen_rsp3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stand-in for the adder: exact for the directed float cases, a fixed mixing function otherwise.
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4080_0000;
        if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'd1;
    endfunction

    function automatic int pick_lat();
        if ($urandom_range(9) == 0) return 0;
        return int'($urandom_range(TO + 3, 1));
    endfunction

    task automatic push_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]        = rv[i];
            bus.req_sub[i]          = rs[i];
            bus.req_a[32*i +: 32]   = ra[i];
            bus.req_b[32*i +: 32]   = rb[i];
        end
    endtask

    task automatic new_op(input int i);
        rv[i] = 1'b1;
        rs[i] = 1'($urandom_range(1));
        ra[i] = $urandom;
        rb[i] = $urandom;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input bit s);
        rv[i] = 1'b1;
        rs[i] = s;
        ra[i] = a;
        rb[i] = b;
        auto_m[i] = 1'b0;
        push_bus();
    endtask

    task automatic tick();
        int             acc_i;
        logic [N-1:0]   exp_rdy;
        logic [N-1:0]   exp_rv;
        acc_i   = -1;
        exp_rdy = '0;
        @(negedge clock);
        if (!out_q) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (acc_i < 0 && rv[j]) acc_i = j;
            end
        end
        if (acc_i >= 0) exp_rdy[acc_i] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (bus.req_ready[3]) seen_ready3 = 1'b1;
        if (acc_i >= 0) begin
            out_q = 1'b1;
            m_id  = acc_i;
            m_acc = cyc;
            m_a   = ra[acc_i];
            m_b   = {rb[acc_i][31] ^ rs[acc_i], rb[acc_i][30:0]};
            m_lat = (force_lat >= 0) ? force_lat : pick_lat();
            if (m_lat >= 1 && m_lat <= TO) begin
                m_rsp  = cyc + 2 + m_lat;
                m_data = core_fn(m_a, m_b);
                m_err  = 1'b0;
            end else begin
                m_rsp  = cyc + TO + 2;
                m_data = 32'h7FC0_0000;
                m_err  = 1'b1;
            end
            cur_lat = m_lat;
            grant_log.push_back(acc_i);
        end

        @(posedge clock);
        #1;
        cyc++;
        core_done = 1'b0;
        if (c_pend) begin
            c_cnt--;
            if (c_cnt == 0) begin
                core_done   = 1'b1;
                core_result = c_res;
                c_pend      = 1'b0;
            end
        end
        if (core_start && cur_lat > 0) begin
            c_pend = 1'b1;
            c_cnt  = cur_lat;
            c_res  = core_fn(core_a, core_b);
        end
        if (stray) begin
            core_done   = 1'b1;
            core_result = $urandom;
            stray       = 1'b0;
        end

        if (out_q && cyc == m_rsp + 1) begin
            out_q  = 1'b0;
            m_last = m_id;
            if (!m_err && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            n_done++;
        end
        exp_rv = (out_q && cyc == m_rsp) ? N'(1 << m_id) : '0;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (bus.rsp_valid[3]) seen_rsp3 = 1'b1;
        if (exp_rv != 0) begin
            check("rsp_data", bus.rsp_data, m_data);
            check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
            last_data    = bus.rsp_data;
            last_err     = bus.rsp_err;
            last_rsp_cyc = cyc;
        end
        check("busy", 32'(busy), 32'(out_q && cyc > m_acc));
        check("core_start", 32'(core_start), 32'(out_q && cyc == m_acc + 1));
        if (out_q && cyc == m_acc + 1) begin
            check("core_a", core_a, m_a);
            check("core_b", core_b, m_b);
        end
        if (core_start) last_core_b = core_b;
        check("op_count", op_count, m_cnt);

        if (acc_i >= 0) begin
            if (auto_m[acc_i]) new_op(acc_i);
            else rv[acc_i] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (i != acc_i) begin
                    if (!rv[i] && $urandom_range(3) == 0) new_op(i);
                    else if (rv[i] && $urandom_range(15) == 0) rv[i] = 1'b0;
                end
            end
        end
        push_bus();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ops(input int k, input int budget);
        int target;
        target = n_done + k;
        while (n_done < target && budget > 0) begin
            tick();
            budget--;
        end
        if (n_done < target) check("wait_ops_bound", 32'(n_done), 32'(target));
    endtask

    task automatic wait_accept(input int budget);
        while (!out_q && budget > 0) begin
            tick();
            budget--;
        end
        if (!out_q) check("wait_accept_bound", 32'(out_q), 32'd1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            rv[i]     = 1'b0;
            auto_m[i] = 1'b0;
        end
        push_bus();
        reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        out_q     = 1'b0;
        m_last    = N - 1;
        m_cnt     = '0;
        c_pend    = 1'b0;
        stray     = 1'b0;
        core_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cyc += 2;
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt_before;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; rs[i] = 1'b0; auto_m[i] = 1'b0;
            ra[i] = '0;   rb[i] = '0;
        end
        push_bus();
        core_done   = 1'b0;
        core_result = '0;
        #2;
        do_reset();

        // Single add through requester 0
        force_lat = 5;
        set_op(0, 32'h4040_0000, 32'h3F80_0000, 1'b0);
        wait_ops(1, 40);
        check("add_data", last_data, 32'h4080_0000);
        check("add_latency", 32'(last_rsp_cyc - m_acc), 32'd7);
        check("add_count", op_count, 32'd1);

        // Subtract through requester 2
        set_op(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        wait_ops(1, 40);
        check("sub_core_b", last_core_b, 32'hBF80_0000);
        check("sub_data", last_data, 32'h4000_0000);
        check("sub_count", op_count, 32'd2);

        // Round robin with all four held valid
        do_reset();
        force_lat = -1;
        for (int i = 0; i < N; i++) begin
            auto_m[i] = 1'b1;
            new_op(i);
        end
        push_bus();
        grant_log.delete();
        wait_ops(8, 400);
        for (int i = 0; i < N; i++) begin
            auto_m[i] = 1'b0;
            rv[i]     = 1'b0;
        end
        push_bus();
        check("rr_grants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check("rr_order", 32'(grant_log[k]), 32'(k % 4));

        // Timeout, then a stray done while idle
        cnt_before = int'(m_cnt);
        force_lat = 0;
        set_op(1, 32'h1234_5678, 32'h0BAD_F00D, 1'b0);
        wait_ops(1, TO + 20);
        check("to_data", last_data, 32'h7FC0_0000);
        check("to_err", 32'(last_err), 32'd1);
        check("to_latency", 32'(last_rsp_cyc - m_acc), 32'(TO + 2));
        check("to_count", op_count, 32'(cnt_before));
        stray = 1'b1;
        run(4);

        // Done on the timeout cycle wins
        force_lat = TO;
        set_op(3, 32'h4040_0000, 32'h3F80_0000, 1'b0);
        wait_ops(1, TO + 20);
        check("tie_err", 32'(last_err), 32'd0);
        check("tie_data", last_data, 32'h4080_0000);

        // Reset while in WAIT
        force_lat = 30;
        set_op(2, 32'hCAFE_0001, 32'h0000_1111, 1'b1);
        wait_accept(10);
        run(4);
        do_reset();
        force_lat = 3;
        grant_log.delete();
        set_op(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        wait_ops(1, 40);
        check("rst_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        check("rst_resume_data", last_data, 32'h4000_0000);

        // Withdrawal: requester 3 drops before the arbiter returns to IDLE
        force_lat = 8;
        set_op(2, 32'h0101_0101, 32'h0202_0202, 1'b0);
        wait_accept(10);
        run(2);
        seen_ready3 = 1'b0;
        seen_rsp3   = 1'b0;
        grant_log.delete();
        set_op(3, 32'h0303_0303, 32'h0404_0404, 1'b0);
        set_op(1, 32'h0505_0505, 32'h0606_0606, 1'b1);
        run(3);
        rv[3] = 1'b0;
        push_bus();
        wait_ops(2, 60);
        check("wd_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        check("wd_ready3", 32'(seen_ready3), 32'd0);
        check("wd_rsp3", 32'(seen_rsp3), 32'd0);

        // Random traffic
        force_lat = -1;
        rand_mode = 1'b1;
        run(600);
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        push_bus();
        if (out_q) wait_ops(1, TO + 30);
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
